// File: rtl/neo_zmc2_shifter.sv
`default_nettype none
// =============================================================================
// Module  : neo_zmc2_shifter
// Brief   : Tile pixel serialiser with holding register, flip and auto-reload.
// Revision: 1.0
// =============================================================================
module neo_zmc2_shifter #(
    parameter int BPP   = 4,
    parameter int PPW   = 8,
    parameter int LANES = 2,
    parameter int AUTO  = 1
) (
    input  logic                   CLK_12M,
    input  logic                   RESET,
    input  logic                   CE,
    input  logic                   WR,
    input  logic                   LOAD,
    input  logic [BPP*PPW-1:0]     CR,
    input  logic                   H,
    output logic [LANES*BPP-1:0]   GD,
    output logic [LANES-1:0]       DOT,
    output logic                   HOLD_FULL,
    output logic                   BUSY,
    output logic                   UNDERRUN
);

    localparam int STEPS = PPW / LANES;
    localparam int CW    = $clog2(STEPS + 1);
    localparam int PW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    logic [BPP*PPW-1:0]   hold_q, hold_d;
    logic                 hold_h_q, hold_h_d;
    logic                 hold_full_q, hold_full_d;
    logic [BPP*PPW-1:0]   sh_q, sh_d;
    logic                 sh_h_q, sh_h_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [LANES*BPP-1:0] gd_q, gd_d;
    logic [LANES-1:0]     dot_q, dot_d;
    logic                 und_q, und_d;

    logic [LANES*BPP-1:0] w_pix;
    logic [LANES-1:0]     w_dot;

    // Lane k of step P is pixel P*LANES+k, mirrored within the word when the
    // flip bit captured with that word is set.
    always_comb begin
        int idx;
        w_pix = '0;
        w_dot = '0;
        for (int k = 0; k < LANES; k++) begin
            idx = int'(ptr_q) * LANES + k;
            if (sh_h_q) begin
                idx = PPW - 1 - idx;
            end
            w_pix[k*BPP +: BPP] = sh_q[idx*BPP +: BPP];
            w_dot[k]            = |sh_q[idx*BPP +: BPP];
        end
    end

    always_comb begin
        hold_d      = hold_q;
        hold_h_d    = hold_h_q;
        hold_full_d = hold_full_q;
        sh_d        = sh_q;
        sh_h_d      = sh_h_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        gd_d        = gd_q;
        dot_d       = dot_q;
        und_d       = 1'b0;

        if (WR) begin
            hold_d      = CR;
            hold_h_d    = H;
            hold_full_d = 1'b1;
        end

        if (LOAD) begin
            // Explicit load wins over any step: the old word is dropped and
            // nothing is emitted this cycle.
            sh_d   = hold_full_q ? hold_q : CR;
            sh_h_d = hold_full_q ? hold_h_q : H;
            cnt_d  = CW'(STEPS);
            ptr_d  = '0;
            if (hold_full_q && !WR) begin
                hold_full_d = 1'b0;
            end
        end else if (CE) begin
            if (cnt_q != '0) begin
                gd_d  = w_pix;
                dot_d = w_dot;
                if (cnt_q == CW'(1)) begin
                    ptr_d = '0;
                    if ((AUTO != 0) && hold_full_q) begin
                        sh_d   = hold_q;
                        sh_h_d = hold_h_q;
                        cnt_d  = CW'(STEPS);
                        if (!WR) begin
                            hold_full_d = 1'b0;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    ptr_d = ptr_q + PW'(1);
                end
            end else begin
                gd_d  = '0;
                dot_d = '0;
                und_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_12M) begin
        if (RESET) begin
            hold_q      <= '0;
            hold_h_q    <= 1'b0;
            hold_full_q <= 1'b0;
            sh_q        <= '0;
            sh_h_q      <= 1'b0;
            cnt_q       <= '0;
            ptr_q       <= '0;
            gd_q        <= '0;
            dot_q       <= '0;
            und_q       <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_h_q    <= hold_h_d;
            hold_full_q <= hold_full_d;
            sh_q        <= sh_d;
            sh_h_q      <= sh_h_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            gd_q        <= gd_d;
            dot_q       <= dot_d;
            und_q       <= und_d;
        end
    end

    assign GD        = gd_q;
    assign DOT       = dot_q;
    assign HOLD_FULL = hold_full_q;
    assign BUSY      = (cnt_q != '0);
    assign UNDERRUN  = und_q;

endmodule
`default_nettype wire

// File: tb/tb_neo_zmc2_shifter.sv
`default_nettype none
// =============================================================================
// Module  : tb_neo_zmc2_shifter
// Brief   : Scoreboard bench for the default and a 2bpp/16ppw/4-lane shifter.
// Revision: 1.0
// =============================================================================
module tb_neo_zmc2_shifter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce  = 1'b0;
    logic        wr  = 1'b0;
    logic        ld  = 1'b0;
    logic [31:0] cr  = '0;
    logic        h   = 1'b0;

    logic [7:0]  gd_a;
    logic [1:0]  dot_a;
    logic        hf_a, busy_a, und_a;
    logic [7:0]  gd_b;
    logic [3:0]  dot_b;
    logic        hf_b, busy_b, und_b;

    typedef struct packed {
        logic [7:0] gd;
        logic [3:0] dot;
        logic       und;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   total = 0;
    int   bad   = 0;
    bit   b_en  = 1'b1;
    bit   step_q = 1'b0;

    always #5 clk = ~clk;

    neo_zmc2_shifter u_dut_a (
        .CLK_12M(clk), .RESET(rst), .CE(ce), .WR(wr), .LOAD(ld), .CR(cr), .H(h),
        .GD(gd_a), .DOT(dot_a), .HOLD_FULL(hf_a), .BUSY(busy_a), .UNDERRUN(und_a)
    );

    neo_zmc2_shifter #(.BPP(2), .PPW(16), .LANES(4), .AUTO(1)) u_dut_b (
        .CLK_12M(clk), .RESET(rst), .CE(ce), .WR(wr), .LOAD(ld), .CR(cr), .H(h),
        .GD(gd_b), .DOT(dot_b), .HOLD_FULL(hf_b), .BUSY(busy_b), .UNDERRUN(und_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // A CE step without LOAD/RESET produces exactly one output the next cycle.
    always @(posedge clk) step_q <= ce && !ld && !rst;

    always @(negedge clk) begin
        exp_t e;
        if (step_q) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_output", 32'd1, 32'd0);
            end else begin
                e = qa.pop_front();
                chk("a_gd", {24'd0, gd_a}, {24'd0, e.gd});
                chk("a_dot", {30'd0, dot_a}, {28'd0, e.dot});
                chk("a_underrun", {31'd0, und_a}, {31'd0, e.und});
            end
            if (b_en) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = qb.pop_front();
                    chk("b_gd", {24'd0, gd_b}, {24'd0, e.gd});
                    chk("b_dot", {28'd0, dot_b}, {28'd0, e.dot});
                    chk("b_underrun", {31'd0, und_b}, {31'd0, e.und});
                end
            end
        end
    end

    task automatic drive(input bit c, input bit l, input bit w, input bit r,
                         input logic [31:0] d, input bit hh);
        ce = c; ld = l; wr = w; rst = r; cr = d; h = hh;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic pa(input logic [7:0] g, input logic [1:0] d, input logic u);
        exp_t e;
        e.gd = g; e.dot = {2'b00, d}; e.und = u;
        qa.push_back(e);
    endtask

    task automatic pb(input logic [7:0] g, input logic [3:0] d);
        exp_t e;
        e.gd = g; e.dot = d; e.und = 1'b0;
        qb.push_back(e);
    endtask

    task automatic ce_step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    localparam logic [31:0] WA = 32'h7654_3210;
    localparam logic [31:0] WB = 32'hFEDC_BA98;

    initial begin
        // Reset, with WR/LOAD/CE asserted to show reset overrides them
        drive(1'b1, 1'b1, 1'b1, 1'b1, WA, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
        chk("rst_gd", {24'd0, gd_a}, 32'd0);
        chk("rst_dot", {30'd0, dot_a}, 32'd0);
        chk("rst_hold_full", {31'd0, hf_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_underrun", {31'd0, und_a}, 32'd0);

        // Basic load, both geometries step 4 times per word
        drive(1'b0, 1'b1, 1'b0, 1'b0, WA, 1'b0);
        chk("basic_busy_a", {31'd0, busy_a}, 32'd1);
        chk("basic_busy_b", {31'd0, busy_b}, 32'd1);
        pa(8'h10, 2'b10, 1'b0); pb(8'h10, 4'b0100);
        pa(8'h32, 2'b11, 1'b0); pb(8'h32, 4'b0101);
        pa(8'h54, 2'b11, 1'b0); pb(8'h54, 4'b1110);
        pa(8'h76, 2'b11, 1'b0); pb(8'h76, 4'b1111);
        for (int i = 0; i < 3; i++) ce_step();
        chk("basic_busy_before_last", {31'd0, busy_a}, 32'd1);
        ce_step();
        chk("basic_busy_drop_a", {31'd0, busy_a}, 32'd0);
        chk("basic_busy_drop_b", {31'd0, busy_b}, 32'd0);

        // Horizontal flip
        drive(1'b0, 1'b1, 1'b0, 1'b0, WA, 1'b1);
        pa(8'h67, 2'b11, 1'b0); pb(8'h9D, 4'b1111);
        pa(8'h45, 2'b11, 1'b0); pb(8'h15, 4'b0111);
        pa(8'h23, 2'b11, 1'b0); pb(8'h8C, 4'b1010);
        pa(8'h01, 2'b01, 1'b0); pb(8'h04, 4'b0010);
        for (int i = 0; i < 4; i++) ce_step();
        b_en = 1'b0;

        // Underrun: exactly one cycle, GD/DOT cleared
        pa(8'h00, 2'b00, 1'b1);
        ce_step();
        idle();
        chk("underrun_pulse_end", {31'd0, und_a}, 32'd0);
        chk("underrun_gd_hold", {24'd0, gd_a}, 32'd0);

        // Seamless reload A -> B
        drive(1'b0, 1'b0, 1'b1, 1'b0, WA, 1'b0);
        chk("seam_hold_full_wr", {31'd0, hf_a}, 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("seam_hold_consumed", {31'd0, hf_a}, 32'd0);
        pa(8'h10, 2'b10, 1'b0); pa(8'h32, 2'b11, 1'b0);
        pa(8'h54, 2'b11, 1'b0); pa(8'h76, 2'b11, 1'b0);
        pa(8'h98, 2'b11, 1'b0); pa(8'hBA, 2'b11, 1'b0);
        pa(8'hDC, 2'b11, 1'b0); pa(8'hFE, 2'b11, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, WB, 1'b0);
        chk("seam_hold_refilled", {31'd0, hf_a}, 32'd1);
        for (int i = 0; i < 3; i++) ce_step();
        chk("seam_hold_after_reload", {31'd0, hf_a}, 32'd0);
        chk("seam_busy_after_reload", {31'd0, busy_a}, 32'd1);
        for (int i = 0; i < 4; i++) ce_step();
        chk("seam_busy_end", {31'd0, busy_a}, 32'd0);

        // LOAD + WR + CE together with the holding register occupied
        drive(1'b0, 1'b0, 1'b1, 1'b0, WA, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, WB, 1'b1);
        chk("simul_no_emit", {24'd0, gd_a}, 32'h0000_00FE);
        chk("simul_hold_full", {31'd0, hf_a}, 32'd1);
        chk("simul_busy", {31'd0, busy_a}, 32'd1);
        pa(8'h10, 2'b10, 1'b0); pa(8'h32, 2'b11, 1'b0);
        pa(8'h54, 2'b11, 1'b0); pa(8'h76, 2'b11, 1'b0);
        pa(8'hEF, 2'b11, 1'b0); pa(8'hCD, 2'b11, 1'b0);
        pa(8'hAB, 2'b11, 1'b0); pa(8'h89, 2'b11, 1'b0);
        for (int i = 0; i < 4; i++) ce_step();
        chk("simul_hold_after_reload", {31'd0, hf_a}, 32'd0);
        for (int i = 0; i < 4; i++) ce_step();

        // Reset mid-word with a pending holding word
        drive(1'b0, 1'b1, 1'b0, 1'b0, WA, 1'b0);
        pa(8'h10, 2'b10, 1'b0); pa(8'h32, 2'b11, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, WB, 1'b0);
        ce_step();
        drive(1'b1, 1'b1, 1'b1, 1'b1, WB, 1'b0);
        chk("midrst_gd", {24'd0, gd_a}, 32'd0);
        chk("midrst_dot", {30'd0, dot_a}, 32'd0);
        chk("midrst_busy", {31'd0, busy_a}, 32'd0);
        chk("midrst_hold_full", {31'd0, hf_a}, 32'd0);
        chk("midrst_underrun", {31'd0, und_a}, 32'd0);
        pa(8'h00, 2'b00, 1'b1);
        ce_step();
        idle();
        idle();

        chk("queue_a_drained", qa.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
